// File: rtl/reg_bank_rw.sv
// Register bank: one synchronous write port, two registered read ports with
// same-edge write forwarding, self-clearing after reset (busy while clearing).
// Define REG_ZERO_HARDWIRED_EN to make entry 0 a read-only zero.

module reg_bank_rd_port #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk_e,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_acc,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_mem,
  output logic [DATA_W-1:0] out
);
  logic [DATA_W-1:0] rd_nxt;

  always_comb begin
    rd_nxt = rd_mem;
    if (wr_acc && (wr_addr == rd_addr)) rd_nxt = wr_data;
`ifdef REG_ZERO_HARDWIRED_EN
    if (rd_addr == '0) rd_nxt = '0;
`endif
    // Outputs stay at zero until the clear sequence has finished.
    if (!run) rd_nxt = '0;
  end

  always_ff @(posedge clk_e or negedge rst)
    if (!rst) out <= '0;
    else      out <= rd_nxt;
endmodule

module reg_bank_rw #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk_e,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              busy,
  output logic              wr_ack
);
  localparam int N      = 1 << ADDR_W;
  localparam int NPORTS = 2;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t                           state, state_nxt;
  logic [ADDR_W-1:0]                ptr;
  logic [N-1:0][DATA_W-1:0]         mem;
  wr_req_t                          mem_wr;
  logic                             run, wr_acc;
  logic [NPORTS-1:0][ADDR_W-1:0]    rd_addr_v;
  logic [NPORTS-1:0][DATA_W-1:0]    rd_q;

  assign run    = (state == RUN);
  assign wr_acc = run & wr_en;
  assign busy   = (state == INIT);

  always_ff @(posedge clk_e or negedge rst)
    if (!rst) state <= INIT;
    else      state <= state_nxt;

  always_comb begin
    state_nxt   = state;
    mem_wr.en   = 1'b0;
    mem_wr.addr = wr_addr;
    mem_wr.data = wr_data;
    case (state)
      INIT: begin
        mem_wr.en   = 1'b1;
        mem_wr.addr = ptr;
        mem_wr.data = '0;
        if (&ptr) state_nxt = RUN;
      end
      RUN: begin
        mem_wr.en = wr_en;
`ifdef REG_ZERO_HARDWIRED_EN
        if (wr_addr == '0) mem_wr.en = 1'b0;
`endif
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk_e or negedge rst)
    if (!rst)              ptr <= '0;
    else if (state == INIT) ptr <= ptr + ADDR_W'(1);

  // Storage has no reset of its own; the INIT sweep is what clears it.
  always_ff @(posedge clk_e)
    if (mem_wr.en) mem[mem_wr.addr] <= mem_wr.data;

  always_ff @(posedge clk_e or negedge rst)
    if (!rst) wr_ack <= 1'b0;
    else      wr_ack <= wr_acc;

  assign rd_addr_v = {rd_addr2, rd_addr1};

  for (genvar g = 0; g < NPORTS; g++) begin : g_rd
    reg_bank_rd_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd (
      .clk_e   (clk_e),
      .rst     (rst),
      .run     (run),
      .wr_acc  (wr_acc),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr_v[g]),
      .rd_mem  (mem[rd_addr_v[g]]),
      .out     (rd_q[g])
    );
  end

  assign out1 = rd_q[0];
  assign out2 = rd_q[1];
endmodule

// File: tb/tb_reg_bank_rw.sv
// Self-checking bench for reg_bank_rw: directed scenarios plus randomized traffic
// checked against an array-based reference model of the bank.
module tb_reg_bank_rw;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int N      = 8;
`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  logic              clk_e = 1'b0;
  logic              rst   = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] out1, out2;
  logic              busy, wr_ack;

  reg_bank_rw #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_e(clk_e), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .out1(out1), .out2(out2),
    .busy(busy), .wr_ack(wr_ack)
  );

  always #5 clk_e = ~clk_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array plus count of clear edges still owed.
  logic [DATA_W-1:0] m_mem [N];
  int                clr_left = N;
  logic [DATA_W-1:0] e_out1 = '0, e_out2 = '0;
  logic              e_ack = 1'b0, e_busy = 1'b1;

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (ZERO_HW && a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  // Advance model by one edge using the inputs present now, then step the clock.
  task automatic cyc();
    logic [DATA_W-1:0] n1, n2;
    logic na;
    if (clr_left > 0) begin
      m_mem[N - clr_left] = '0;
      clr_left--;
      n1 = '0; n2 = '0; na = 1'b0;
    end else begin
      n1 = m_read(rd_addr1);
      n2 = m_read(rd_addr2);
      na = wr_en;
      if (wr_en && !(ZERO_HW && wr_addr == 0)) m_mem[wr_addr] = wr_data;
    end
    @(posedge clk_e); #1;
    e_out1 = n1; e_out2 = n2; e_ack = na; e_busy = (clr_left > 0);
  endtask

  task automatic assert_reset();
    #2 rst = 1'b0;
    clr_left = N;
    e_out1 = '0; e_out2 = '0; e_ack = 1'b0; e_busy = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_e);
    @(negedge clk_e) rst = 1'b1;
  endtask

  task automatic test_reset();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd9;
    assert_reset();
    n_checks++;
    if ({busy, wr_ack, out1, out2} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b ack=%b o1=%h o2=%h, want busy=1 ack=0 o1=0 o2=0",
               busy, wr_ack, out1, out2);
    end
    release_reset();
    for (int i = 1; i <= N + 1; i++) begin
      cyc();
      n_checks++;
      if ({busy, wr_ack, out1, out2} !== {e_busy, e_ack, e_out1, e_out2}) begin
        n_fail++;
        $display("FAIL clear_edge%0d: got busy=%b ack=%b o1=%h o2=%h, want busy=%b ack=%b o1=%h o2=%h",
                 i, busy, wr_ack, out1, out2, e_busy, e_ack, e_out1, e_out2);
      end
    end
    n_checks++;
    if (wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL first_ack_edge9: got ack=%b, want 1", wr_ack);
    end
    wr_en = 1'b0; rd_addr1 = 3'd2;
    cyc();
    n_checks++;
    if (out1 !== 4'd9 || wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_addr2: got o1=%h ack=%b, want o1=9 ack=0", out1, wr_ack);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'd5; rd_addr1 = 3'd0; rd_addr2 = 3'd1;
    cyc();
    n_checks++;
    if ({wr_ack, out1, out2} !== {e_ack, e_out1, e_out2} || wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ack: got ack=%b o1=%h o2=%h, want ack=1 o1=%h o2=%h",
               wr_ack, out1, out2, e_out1, e_out2);
    end
    wr_en = 1'b0; rd_addr1 = 3'd3; rd_addr2 = 3'd4;
    cyc();
    n_checks++;
    if (out1 !== 4'd5 || out2 !== 4'd0 || wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL write_then_read: got o1=%h o2=%h ack=%b, want o1=5 o2=0 ack=0",
               out1, out2, wr_ack);
    end
  endtask

  task automatic test_forward();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'd7; rd_addr1 = 3'd6; rd_addr2 = 3'd6;
    cyc();
    n_checks++;
    if (out1 !== 4'd7 || out2 !== 4'd7 || wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL forward_both: got o1=%h o2=%h ack=%b, want o1=7 o2=7 ack=1",
               out1, out2, wr_ack);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
      rd_addr1 = 3'(i); rd_addr2 = 3'd7;
      cyc();
      n_checks++;
      if (wr_ack !== 1'b1 || {out1, out2} !== {e_out1, e_out2}) begin
        n_fail++;
        $display("FAIL b2b_write%0d: got ack=%b o1=%h o2=%h, want ack=1 o1=%h o2=%h",
                 i, wr_ack, out1, out2, e_out1, e_out2);
      end
    end
    wr_en = 1'b0; rd_addr1 = 3'd0; rd_addr2 = 3'd1;
    cyc();
    n_checks++;
    if (out1 !== (ZERO_HW ? 4'd0 : 4'd1) || out2 !== 4'd2 || wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_read01: got o1=%h o2=%h ack=%b, want o1=%0d o2=2 ack=0",
               out1, out2, wr_ack, ZERO_HW ? 0 : 1);
    end
    rd_addr1 = 3'd2;
    cyc();
    n_checks++;
    if (out1 !== 4'd3) begin
      n_fail++;
      $display("FAIL b2b_read2: got o1=%h, want 3", out1);
    end
  endtask

  task automatic test_reset_mid();
    assert_reset();
    release_reset();
    repeat (3) cyc();
    assert_reset();
    n_checks++;
    if ({busy, wr_ack, out1, out2} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_init: got busy=%b ack=%b o1=%h o2=%h, want busy=1 ack=0 o1=0 o2=0",
               busy, wr_ack, out1, out2);
    end
    release_reset();
    for (int i = 1; i <= N; i++) begin
      cyc();
      n_checks++;
      if ({busy, wr_ack, out1, out2} !== {e_busy, e_ack, e_out1, e_out2}) begin
        n_fail++;
        $display("FAIL reclear_edge%0d: got busy=%b ack=%b o1=%h o2=%h, want busy=%b ack=%b o1=%h o2=%h",
                 i, busy, wr_ack, out1, out2, e_busy, e_ack, e_out1, e_out2);
      end
    end
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'd8; rd_addr1 = 3'd5; rd_addr2 = 3'd5;
    cyc();
    // A second write is pending when reset hits; it must be dropped.
    wr_addr = 3'd1; wr_data = 4'd4;
    assert_reset();
    n_checks++;
    if ({busy, wr_ack, out1, out2} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_in_run: got busy=%b ack=%b o1=%h o2=%h, want busy=1 ack=0 o1=0 o2=0",
               busy, wr_ack, out1, out2);
    end
    release_reset();
    repeat (N) cyc();
    wr_en = 1'b0; rd_addr1 = 3'd5; rd_addr2 = 3'd1;
    cyc();
    n_checks++;
    if (out1 !== 4'd0 || out2 !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_read: got o1=%h o2=%h busy=%b, want o1=0 o2=0 busy=0",
               out1, out2, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 3'($urandom);
      wr_data  = 4'($urandom);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
      cyc();
      n_checks++;
      if ({busy, wr_ack, out1, out2} !== {e_busy, e_ack, e_out1, e_out2}) begin
        n_fail++;
        $display("FAIL random%0d: got busy=%b ack=%b o1=%h o2=%h, want busy=%b ack=%b o1=%h o2=%h",
                 i, busy, wr_ack, out1, out2, e_busy, e_ack, e_out1, e_out2);
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank_rw.md
# reg_bank_rw

Register bank with one synchronous write port and two registered read ports, sitting directly upstream of the two-digit seven-segment multiplexer. Its read outputs `out1`/`out2` drive that multiplexer's digit inputs. After every reset it runs a self-clearing sequence over all entries and flags `busy` while doing so. Accepted writes are acknowledged, and same-cycle read-after-write is forwarded.

## Interface
- `ADDR_W`, default 3: address width; depth N = 2^ADDR_W entries.
- `DATA_W`, default 4: entry width (one BCD digit).
- `clk_e` input 1: clock; all state changes on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: write request, sampled each rising edge.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input DATA_W: write data.
- `rd_addr1` input ADDR_W: read address, port 1.
- `rd_addr2` input ADDR_W: read address, port 2.
- `out1` output DATA_W: registered read data, port 1.
- `out2` output DATA_W: registered read data, port 2.
- `busy` output 1: high while the clear sequence runs; writes are refused.
- `wr_ack` output 1: one-cycle pulse confirming an accepted write.

## Operation
- Storage: N x DATA_W register array, not reset directly. It is cleared by the FSM.
- FSM states:
  - INIT: clear pointer `ptr` (ADDR_W bits) writes 0 to `mem[ptr]` each edge and increments. After writing entry N-1, go to RUN.
  - RUN: normal operation. No exit except reset.
- Reset (`rst`=0, async, any time including mid-INIT or mid-write):
  - state=INIT, `ptr`=0, `busy`=1, `wr_ack`=0, `out1`=0, `out2`=0.
  - An in-flight write is discarded with no ack.
- INIT:
  - `wr_en` is ignored: no array update, no `wr_ack`.
  - `out1`/`out2` hold 0.
- RUN, write: at an edge with `wr_en`=1, `mem[wr_addr]` <= `wr_data` and `wr_ack` <= 1. Otherwise `wr_ack` <= 0.
- RUN, read: each edge, `out1` <= `mem[rd_addr1]` and `out2` <= `mem[rd_addr2]`.
- Forwarding: if a write is accepted at the same edge and `wr_addr` equals the read address, that port loads `wr_data` instead of the old entry. Both ports forward independently; both may forward at once.
- `ptr` wrap: the clear ends at N-1. `ptr` is not used after INIT, and its value in RUN is don't-care.
- Back-to-back writes, one per cycle, are accepted indefinitely. Each produces its own `wr_ack` pulse.

## Timing
- Clear duration:
  - Edges 1..N after reset release clear entries 0..N-1.
  - `busy` falls at edge N.
  - The first write can be accepted at edge N+1.
- Write latency: data is visible in the array after the accepting edge. `wr_ack` is high for exactly the following cycle.
- Read latency: 1 cycle from address to `out1`/`out2`.
- Read-after-write to the same address at the same edge: new data appears on the output after that edge (0 extra latency, via forwarding).
- Write-then-read in the next cycle: returns the new data.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro `REG_ZERO_HARDWIRED_EN`:
  - Defined: entry 0 is read-only zero.
    - Writes to address 0 in RUN are still acknowledged (`wr_ack` pulses) but leave the array unchanged.
    - Reads of address 0 always return 0, including the forwarding case.
  - Undefined: entry 0 behaves like every other entry.

## Test plan
- Reset release, `wr_en`=1 held from edge 1 with `wr_addr`=2, `wr_data`=9 -> `busy`=1 for 8 cycles; no `wr_ack` on edges 1..8; first `wr_ack` after edge 9; then reading addr 2 -> `out1`=9.
- RUN: write 5 to addr 3, then next cycle `rd_addr1`=3, `rd_addr2`=4 -> `out1`=5, `out2`=0, one `wr_ack` pulse.
- RUN: same edge write 7 to addr 6 with `rd_addr1`=`rd_addr2`=6 -> both outputs 7 after that edge (forwarding).
- RUN: writes of 1,2,3 to addrs 0,1,2 on consecutive edges -> `wr_ack` high 3 consecutive cycles; readback 1,2,3 (macro undefined) or 0,2,3 (macro defined).
- Assert `rst` mid-INIT at edge 4, and again in RUN after writing 8 to addr 5 -> outputs 0 and `busy`=1 immediately; full 8-cycle clear restarts; addr 5 reads 0 afterwards.
